// File: rtl/sdram_word_bridge.sv
// Splits 32-bit word requests into two 16-bit Avalon-MM SDRAM transactions (low half first)
// and reassembles pipelined read beats into 32-bit responses, bounding outstanding read data.
module sdram_word_bridge #(
   parameter  int ADDR_W   = 24,
   parameter  int MAX_PEND = 8,
   localparam int PW       = $clog2(MAX_PEND + 1)
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              rsp_valid,
   output logic [31:0]       rsp_data,
   output logic [ADDR_W:0]   sdram_address,
   output logic [1:0]        sdram_byteenable_n,
   output logic              sdram_chipselect,
   output logic [15:0]       sdram_writedata,
   output logic              sdram_read_n,
   output logic              sdram_write_n,
   input  logic [15:0]       sdram_readdata,
   input  logic              sdram_readdatavalid,
   input  logic              sdram_waitrequest,
   output logic [PW-1:0]     pend_cnt,
   output logic              err_orphan
);

   // state | meaning
   // IDLE  | no command driven; may accept a request
   // LO    | low-half command on the bus, waiting for waitrequest to drop
   // HI    | high-half command on the bus, waiting for waitrequest to drop
   typedef enum logic [1:0] {IDLE, LO, HI} state_t;

   state_t             state;
   logic [ADDR_W-1:0]  addr_q;
   logic [15:0]        wdata_hi;
   logic [1:0]         be_hi;
   logic               write_q;
   logic               phase;
   logic [15:0]        lo_reg;
   logic               accept;
   logic               rd_accept;
   logic               beat_ok;

   assign req_ready = (state == IDLE) && (pend_cnt <= PW'(MAX_PEND - 2));
   assign accept    = req_valid && req_ready;
   assign rd_accept = accept && !req_write;
   assign beat_ok   = sdram_readdatavalid && (pend_cnt != '0);

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state              <= IDLE;
         addr_q             <= '0;
         wdata_hi           <= '0;
         be_hi              <= '0;
         write_q            <= 1'b0;
         sdram_address      <= '0;
         sdram_byteenable_n <= 2'b11;
         sdram_chipselect   <= 1'b0;
         sdram_writedata    <= '0;
         sdram_read_n       <= 1'b1;
         sdram_write_n      <= 1'b1;
         pend_cnt           <= '0;
         phase              <= 1'b0;
         lo_reg             <= '0;
         rsp_valid          <= 1'b0;
         rsp_data           <= '0;
         err_orphan         <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q   <= req_addr;
                  wdata_hi <= req_wdata[31:16];
                  be_hi    <= req_be[3:2];
                  write_q  <= req_write;
                  if (!req_write || req_be[1:0] != 2'b00) begin
                     state              <= LO;
                     sdram_address      <= {req_addr, 1'b0};
                     sdram_writedata    <= req_wdata[15:0];
                     sdram_byteenable_n <= req_write ? ~req_be[1:0] : 2'b00;
                     sdram_chipselect   <= 1'b1;
                     sdram_read_n       <= req_write;
                     sdram_write_n      <= !req_write;
                  end else if (req_be[3:2] != 2'b00) begin
                     state              <= HI;
                     sdram_address      <= {req_addr, 1'b1};
                     sdram_writedata    <= req_wdata[31:16];
                     sdram_byteenable_n <= ~req_be[3:2];
                     sdram_chipselect   <= 1'b1;
                     sdram_read_n       <= 1'b1;
                     sdram_write_n      <= 1'b0;
                  end
               end
            end
            LO: begin
               if (!sdram_waitrequest) begin
                  if (!write_q || be_hi != 2'b00) begin
                     state              <= HI;
                     sdram_address      <= {addr_q, 1'b1};
                     sdram_writedata    <= wdata_hi;
                     sdram_byteenable_n <= write_q ? ~be_hi : 2'b00;
                  end else begin
                     state              <= IDLE;
                     sdram_chipselect   <= 1'b0;
                     sdram_read_n       <= 1'b1;
                     sdram_write_n      <= 1'b1;
                     sdram_byteenable_n <= 2'b11;
                  end
               end
            end
            HI: begin
               if (!sdram_waitrequest) begin
                  state              <= IDLE;
                  sdram_chipselect   <= 1'b0;
                  sdram_read_n       <= 1'b1;
                  sdram_write_n      <= 1'b1;
                  sdram_byteenable_n <= 2'b11;
               end
            end
            default: state <= IDLE;
         endcase

         // Reservation happens at accept, so a beat can retire in the same cycle (net +1).
         pend_cnt <= pend_cnt + (rd_accept ? PW'(2) : PW'(0)) - (beat_ok ? PW'(1) : PW'(0));
         if (sdram_readdatavalid && pend_cnt == '0)
            err_orphan <= 1'b1;

         if (beat_ok) begin
            phase <= !phase;
            if (!phase) begin
               lo_reg <= sdram_readdata;
            end else begin
               rsp_data  <= {sdram_readdata, lo_reg};
               rsp_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/sdram_word_bridge.md
# sdram_word_bridge

Upstream front-end for the 16-bit Avalon-MM SDRAM controller slave. It accepts 32-bit word read/write requests from user logic over a valid/ready handshake and splits each request into two 16-bit Avalon transactions, low half first. It honours `sdram_waitrequest` and tracks pipelined reads so that outstanding data never exceeds a fixed budget. Returning halfword beats are reassembled into one 32-bit response.

## Interface

**Parameters**
- `ADDR_W`, default 24: word address width. The SDRAM halfword address is {`req_addr`, half}, i.e. `ADDR_W`+1 = 25 bits.
- `MAX_PEND`, default 8: maximum outstanding read halfwords. Must be even and ≥2.

**Ports**
- `clk_clk` in 1: single clock.
- `reset_reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: 32-bit word address.
- `req_wdata` in 32: write data.
- `req_be` in 4: active-high byte enables for writes; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse carrying read data. No backpressure.
- `rsp_data` out 32: reassembled read word {hi, lo}.
- `sdram_address` out 25, `sdram_byteenable_n` out 2, `sdram_chipselect` out 1, `sdram_writedata` out 16, `sdram_read_n` out 1, `sdram_write_n` out 1: Avalon command to the controller.
- `sdram_readdata` in 16, `sdram_readdatavalid` in 1, `sdram_waitrequest` in 1: Avalon response from the controller.
- `pend_cnt` out clog2(`MAX_PEND`+1): reserved, not-yet-returned read halfwords.
- `err_orphan` out 1: sticky; set when a read beat arrives while `pend_cnt`==0.

## Operation

**State machine:** IDLE, LO, HI.
- IDLE: `req_ready` = (`pend_cnt` ≤ `MAX_PEND`-2). It is combinational from state and `pend_cnt` only.
- On accept, latch addr/wdata/be/write:
  - Read: reserve 2 (`pend_cnt` += 2), go to LO.
  - Write, `req_be[1:0]`≠0: go to LO.
  - Write, `req_be[1:0]`==0 and `req_be[3:2]`≠0: go to HI.
  - Write, `req_be`==0: accept and drop; stay in IDLE.
- LO command:
  - `sdram_address` = {addr, 1'b0}, `sdram_writedata` = wdata[15:0].
  - `sdram_byteenable_n` = ~be[1:0] for writes, 2'b00 for reads.
  - `sdram_chipselect`=1; `sdram_read_n`/`sdram_write_n` = ~read / ~write.
- In LO, when `sdram_waitrequest`==0: go to HI if the high half is needed, else IDLE. Reads always need the high half; writes need it when `req_be[3:2]`≠0.
- HI command: address {addr, 1'b1}, data wdata[31:16], byte enables from be[3:2]. In HI, when `sdram_waitrequest`==0, go to IDLE.
- While `sdram_waitrequest`=1, all command outputs hold stable.
- Command outputs are decoded from state and latched registers only. There is no combinational path from `req_*` to `sdram_*`.
- `pend_cnt`:
  - +2 on read accept, -1 on each `sdram_readdatavalid`.
  - If both occur in the same cycle, the net change is +1.
  - It never underflows. A beat arriving at 0 is discarded and sets `err_orphan`.
- Reassembly:
  - A phase bit toggles on each counted beat.
  - Phase 0: store the beat in `lo_reg`.
  - Phase 1: register `rsp_data` = {`sdram_readdata`, `lo_reg`} and pulse `rsp_valid` on the next cycle.
- **Reset values:**
  - State IDLE, `pend_cnt`=0, phase=0, `err_orphan`=0.
  - `rsp_valid`=0, `rsp_data`=0.
  - `sdram_read_n`=1, `sdram_write_n`=1, `sdram_chipselect`=0, `sdram_byteenable_n`=2'b11, `sdram_address`=0, `sdram_writedata`=0.
- **Reset mid-operation:** any in-flight command is abandoned immediately, and pending reads are forgotten. Late beats are treated as orphans.

## Timing

- Accept at cycle T: the LO command is visible at T+1.
- With no waitrequest: HI at T+2, IDLE at T+3, and `req_ready` can reassert at T+3. Peak throughput is one word per 3 cycles.
- Each cycle of `sdram_waitrequest`=1 extends the current half by exactly one cycle.
- Read response: `rsp_valid` is asserted the cycle after the second `sdram_readdatavalid` of the pair. Responses are in request order.
- The `pend_cnt` limit stalls `req_ready` in IDLE only. Commands already in LO/HI always complete.

## Test plan

- **Write:** `req_addr`=0x000010, `req_wdata`=0xDEADBEEF, `req_be`=0xF, no waitrequest -> write at 0x0000020 data 0xBEEF be_n 00 on T+1, then 0x0000021 data 0xDEAD on T+2; `req_ready` high at T+3.
- **Waitrequest stall:** waitrequest held 3 cycles during LO -> command outputs frozen; HI appears 3 cycles later; no duplicate command.
- **Read:** read word 0x000004; controller returns 0x5678 then 0x1234 -> `rsp_valid` one cycle with `rsp_data`=0x12345678; `pend_cnt` goes 0→2→1→0.
- **Pending limit:** `MAX_PEND`=8, read beats withheld -> 4 reads accepted, `pend_cnt`=8, `req_ready`=0. One beat returns -> `pend_cnt`=7, `req_ready` stays 0. A second beat returns -> `pend_cnt`=6, `req_ready` reasserts.
- **Partial writes:** `req_be`=0xC -> HI write only, addr odd, be_n 00. `req_be`=0x0 -> accepted, no Avalon activity.
- **Reset mid-read:** reset asserted in HI with 2 beats pending -> outputs at reset values the next cycle. A late beat gives no `rsp_valid`, `err_orphan`=1, and `pend_cnt` stays 0.
